// File: rtl/hazard_ctrl_if.sv
// Hazard controller bus: ID/EX hazard inputs, interrupt request and the
// pipeline control outputs (PC/IF-ID enables, flushes, PC mux select).
// The pipeline side uses the master modport and hazard_ctrl uses the slave.
interface hazard_ctrl_if;
  logic [4:0] ID_Rs;
  logic [4:0] ID_Rt;
  logic       ID_UsesRt;
  logic       ID_Jump;
  logic       ID_MulDiv;
  logic       EX_MemRead;
  logic [4:0] EX_Rt;
  logic       EX_BranchTaken;
  logic       IRQ;
  logic       PC_Write;
  logic       IF_ID_Write;
  logic       ID_Flush;
  logic       EX_Flush;
  logic [1:0] PC_Sel;
  logic       IRQ_Ack;
  logic       Busy;

  modport master (
    output ID_Rs, ID_Rt, ID_UsesRt, ID_Jump, ID_MulDiv,
    output EX_MemRead, EX_Rt, EX_BranchTaken, IRQ,
    input  PC_Write, IF_ID_Write, ID_Flush, EX_Flush, PC_Sel, IRQ_Ack, Busy
  );

  modport slave (
    input  ID_Rs, ID_Rt, ID_UsesRt, ID_Jump, ID_MulDiv,
    input  EX_MemRead, EX_Rt, EX_BranchTaken, IRQ,
    output PC_Write, IF_ID_Write, ID_Flush, EX_Flush, PC_Sel, IRQ_Ack, Busy
  );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: five-stage pipeline hazard/sequencing controller.
// Resolves load-use stalls, taken branches, jumps and interrupt entry, and
// drives PC/IF-ID write enables, IF/ID and ID/EX flushes and the PC mux select.
// Optional multi-cycle mul/div stall is built when HAZARD_MULDIV_EN is defined.
// Decision outputs are combinational from state and inputs.
module hazard_ctrl #(
  parameter int MD_CYCLES = 32
) (
  input logic         clk,
  input logic         reset,
  hazard_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
`ifdef HAZARD_MULDIV_EN
    MD_WAIT   = 2'd2,
`endif
    IRQ_ENTER = 2'd1
  } state_t;

  state_t     state_r;
  state_t     state_s;
  logic       armed_r;
  logic       lu_s;
  logic       pc_write_s;
  logic       if_id_write_s;
  logic       id_flush_s;
  logic       ex_flush_s;
  logic [1:0] pc_sel_s;
  logic       irq_ack_s;
  logic       busy_s;

`ifdef HAZARD_MULDIV_EN
  localparam int CNT_W = $clog2(MD_CYCLES);
  logic [CNT_W-1:0] cnt_r;
  logic             md_done_r;
`else
  logic unused_muldiv;
  assign unused_muldiv = bus.ID_MulDiv ^ MD_CYCLES[0];
`endif

  // A load in EX whose destination is read by the instruction in ID.
  assign lu_s = bus.EX_MemRead && (bus.EX_Rt != 5'd0) &&
                ((bus.EX_Rt == bus.ID_Rs) || (bus.ID_UsesRt && (bus.EX_Rt == bus.ID_Rt)));

  // Next-state selection and pipeline control outputs, reset forcing last.
  always_comb begin
    state_s       = state_r;
    pc_write_s    = 1'b1;
    if_id_write_s = 1'b1;
    id_flush_s    = 1'b0;
    ex_flush_s    = 1'b0;
    pc_sel_s      = 2'd0;
    irq_ack_s     = 1'b0;
    busy_s        = 1'b0;
    case (state_r)
      RUN: begin
        if (bus.EX_BranchTaken) begin
          pc_sel_s   = 2'd1;
          id_flush_s = 1'b1;
          ex_flush_s = 1'b1;
        end else if (lu_s) begin
          pc_write_s    = 1'b0;
          if_id_write_s = 1'b0;
          ex_flush_s    = 1'b1;
        end else if (bus.IRQ && armed_r) begin
          state_s = IRQ_ENTER;
`ifdef HAZARD_MULDIV_EN
        end else if (bus.ID_MulDiv && !md_done_r) begin
          // The mul/div itself moves into EX now; stalling starts next cycle.
          state_s = MD_WAIT;
`endif
        end else if (bus.ID_Jump) begin
          pc_sel_s   = 2'd2;
          id_flush_s = 1'b1;
        end else begin
          state_s = RUN;
        end
      end
      IRQ_ENTER: begin
        pc_sel_s   = 2'd3;
        id_flush_s = 1'b1;
        ex_flush_s = 1'b1;
        irq_ack_s  = 1'b1;
        busy_s     = 1'b1;
        state_s    = RUN;
      end
`ifdef HAZARD_MULDIV_EN
      MD_WAIT: begin
        pc_write_s    = 1'b0;
        if_id_write_s = 1'b0;
        ex_flush_s    = 1'b1;
        busy_s        = 1'b1;
        if (cnt_r == {CNT_W{1'b0}}) begin
          state_s = RUN;
        end else begin
          state_s = MD_WAIT;
        end
      end
`endif
      default: begin
        state_s = RUN;
      end
    endcase
    if (reset) begin
      pc_write_s    = 1'b0;
      if_id_write_s = 1'b0;
      id_flush_s    = 1'b1;
      ex_flush_s    = 1'b1;
      pc_sel_s      = 2'd0;
      irq_ack_s     = 1'b0;
      busy_s        = 1'b0;
    end else begin
      busy_s = busy_s;
    end
  end

  assign bus.PC_Write    = pc_write_s;
  assign bus.IF_ID_Write = if_id_write_s;
  assign bus.ID_Flush    = id_flush_s;
  assign bus.EX_Flush    = ex_flush_s;
  assign bus.PC_Sel      = pc_sel_s;
  assign bus.IRQ_Ack     = irq_ack_s;
  assign bus.Busy        = busy_s;

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= RUN;
    end else begin
      state_r <= state_s;
    end
  end

  // Interrupt re-arm: disarm on entry, re-arm once the request line drops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      armed_r <= 1'b1;
    end else if (state_r == IRQ_ENTER) begin
      armed_r <= 1'b0;
    end else if (!bus.IRQ) begin
      armed_r <= 1'b1;
    end else begin
      armed_r <= armed_r;
    end
  end

`ifdef HAZARD_MULDIV_EN
  // Mul/div occupancy counter, loaded on entry and counted down while waiting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if ((state_r == RUN) && (state_s == MD_WAIT)) begin
      cnt_r <= CNT_W'(MD_CYCLES - 1);
    end else if ((state_r == MD_WAIT) && (cnt_r != {CNT_W{1'b0}})) begin
      cnt_r <= cnt_r - CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Marks the first RUN cycle after a stall so the same mul/div is not re-issued.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      md_done_r <= 1'b0;
    end else if ((state_r == MD_WAIT) && (cnt_r == {CNT_W{1'b0}})) begin
      md_done_r <= 1'b1;
    end else if (state_r == RUN) begin
      md_done_r <= 1'b0;
    end else begin
      md_done_r <= md_done_r;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios followed by
// randomized traffic, all compared against a cycle-level behavioural model.
// Output vector layout: {PC_Write, IF_ID_Write, ID_Flush, EX_Flush, PC_Sel[1:0], IRQ_Ack, Busy}
module tb_hazard_ctrl;
  localparam int MDC = 4;
`ifdef HAZARD_MULDIV_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif

  localparam logic [7:0] O_DEF   = 8'b1100_0000;
  localparam logic [7:0] O_RST   = 8'b0011_0000;
  localparam logic [7:0] O_LU    = 8'b0001_0000;
  localparam logic [7:0] O_BR    = 8'b1111_0100;
  localparam logic [7:0] O_JMP   = 8'b1110_1000;
  localparam logic [7:0] O_IRQ   = 8'b1111_1111;
  localparam logic [7:0] O_MD    = 8'b0001_0001;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hazard_ctrl_if bus ();
  hazard_ctrl #(.MD_CYCLES(MDC)) dut (.clk(clk), .reset(reset), .bus(bus));

  int checks = 0;
  int failures = 0;

  // Behavioural model state: pending interrupt entry, stall cycles left,
  // interrupt armed, and "just returned from a mul/div stall".
  bit m_enter;
  bit m_armed;
  bit m_md_done;
  int m_md_left;
  bit m_last_ack;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] dut_out();
    return {bus.PC_Write, bus.IF_ID_Write, bus.ID_Flush, bus.EX_Flush,
            bus.PC_Sel, bus.IRQ_Ack, bus.Busy};
  endfunction

  function automatic bit m_lu();
    return bus.EX_MemRead && (bus.EX_Rt != 5'd0) &&
           ((bus.EX_Rt == bus.ID_Rs) || (bus.ID_UsesRt && (bus.EX_Rt == bus.ID_Rt)));
  endfunction

  function automatic logic [7:0] m_out();
    if (m_enter) return O_IRQ;
    if (m_md_left > 0) return O_MD;
    if (bus.EX_BranchTaken) return O_BR;
    if (m_lu()) return O_LU;
    if (bus.IRQ && m_armed) return O_DEF;
    if (MD_EN && bus.ID_MulDiv && !m_md_done) return O_DEF;
    if (bus.ID_Jump) return O_JMP;
    return O_DEF;
  endfunction

  task automatic m_reset();
    m_enter   = 1'b0;
    m_armed   = 1'b1;
    m_md_done = 1'b0;
    m_md_left = 0;
  endtask

  task automatic m_advance();
    bit in_run;
    bit take_irq;
    bit take_md;
    in_run   = !m_enter && (m_md_left == 0);
    take_irq = in_run && !bus.EX_BranchTaken && !m_lu() && bus.IRQ && m_armed;
    take_md  = MD_EN && in_run && !bus.EX_BranchTaken && !m_lu() && !take_irq &&
               bus.ID_MulDiv && !m_md_done;
    if (m_enter) m_armed = 1'b0;
    else if (!bus.IRQ) m_armed = 1'b1;
    if (m_md_left > 0) begin
      m_md_left--;
      m_md_done = (m_md_left == 0);
    end else begin
      m_md_done = 1'b0;
    end
    if (take_md) m_md_left = MDC;
    m_enter = take_irq;
  endtask

  // One clock: inputs already driven; compare at negedge, advance model, move past posedge.
  task automatic step(input string tag, output logic [7:0] got);
    logic [7:0] e;
    @(negedge clk);
    e = m_out();
    got = dut_out();
    m_last_ack = e[1];
    check(tag, {24'd0, got}, {24'd0, e});
    m_advance();
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset asserted mid-cycle, held across one edge.
  task automatic do_reset();
    reset = 1'b1;
    #1;
    check("rst_async", {24'd0, dut_out()}, {24'd0, O_RST});
    m_reset();
    @(negedge clk);
    check("rst_hold", {24'd0, dut_out()}, {24'd0, O_RST});
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic idle();
    bus.ID_Rs = 5'd0; bus.ID_Rt = 5'd0; bus.ID_UsesRt = 1'b0;
    bus.ID_Jump = 1'b0; bus.ID_MulDiv = 1'b0; bus.EX_MemRead = 1'b0;
    bus.EX_Rt = 5'd0; bus.EX_BranchTaken = 1'b0;
  endtask

  logic [7:0] g;
  int acks;
  int first;
  int busy_cnt;
  int pcw0_cnt;
  bit irq_acked;

  initial begin
    idle();
    bus.IRQ = 1'b0;
    m_last_ack = 1'b0;
    do_reset();

    // Load-use stall, then the r0 exemption.
    bus.EX_MemRead = 1'b1; bus.EX_Rt = 5'd5; bus.ID_Rs = 5'd5;
    step("lu", g); check("lu_out", {24'd0, g}, {24'd0, O_LU});
    idle();
    step("lu_after", g); check("lu_after_out", {24'd0, g}, {24'd0, O_DEF});
    bus.EX_MemRead = 1'b1; bus.EX_Rt = 5'd0; bus.ID_Rs = 5'd0;
    step("lu_r0", g); check("lu_r0_out", {24'd0, g}, {24'd0, O_DEF});
    bus.EX_Rt = 5'd7; bus.ID_Rt = 5'd7; bus.ID_Rs = 5'd1; bus.ID_UsesRt = 1'b1;
    step("lu_rt", g); check("lu_rt_out", {24'd0, g}, {24'd0, O_LU});
    bus.ID_UsesRt = 1'b0;
    step("lu_rt_unused", g); check("lu_rt_unused_out", {24'd0, g}, {24'd0, O_DEF});

    // Branch beats load-use and jump.
    bus.EX_Rt = 5'd5; bus.ID_Rs = 5'd5; bus.ID_Jump = 1'b1; bus.EX_BranchTaken = 1'b1;
    step("br_prio", g); check("br_prio_out", {24'd0, g}, {24'd0, O_BR});
    idle(); bus.ID_Jump = 1'b1;
    step("jump", g); check("jump_out", {24'd0, g}, {24'd0, O_JMP});
    idle();

    // Interrupt held 20 cycles: exactly one ack, one cycle after it is seen.
    repeat (10) step("irq_idle", g);
    bus.IRQ = 1'b1; acks = 0; first = -1;
    for (int i = 0; i < 20; i++) begin
      step("irq_hold", g);
      if (g[1]) begin acks++; if (first < 0) first = i; end
    end
    check("irq_ack_cnt", acks, 1);
    check("irq_ack_pos", first, 1);
    bus.IRQ = 1'b0;
    repeat (3) step("irq_low", g);
    bus.IRQ = 1'b1; acks = 0;
    for (int i = 0; i < 10; i++) begin
      step("irq_again", g);
      if (g[1]) acks++;
    end
    check("irq_reack_cnt", acks, 1);
    bus.IRQ = 1'b0;
    step("irq_rel", g);

`ifdef HAZARD_MULDIV_EN
    // Mul/div stall, then one RUN cycle that ignores the still-high ID_MulDiv.
    bus.ID_MulDiv = 1'b1;
    step("md_enter", g); check("md_enter_out", {24'd0, g}, {24'd0, O_DEF});
    busy_cnt = 0; pcw0_cnt = 0;
    for (int i = 0; i < MDC; i++) begin
      step("md_wait", g);
      busy_cnt += int'(g[0]);
      pcw0_cnt += int'(!g[7]);
    end
    check("md_busy_cnt", busy_cnt, MDC);
    check("md_pcw0_cnt", pcw0_cnt, MDC);
    step("md_ignore", g); check("md_ignore_out", {24'd0, g}, {24'd0, O_DEF});
    // Second stall with an IRQ raised mid-stall: acked right after return to RUN.
    step("md_enter2", g);
    step("md_stall0", g);
    bus.IRQ = 1'b1; bus.ID_MulDiv = 1'b0; first = -1;
    for (int i = 0; i < 8; i++) begin
      step("md_irq", g);
      if (g[1] && first < 0) first = i;
    end
    check("md_irq_ack_pos", first, 4);
    bus.IRQ = 1'b0;
    step("md_irq_rel", g);
    // Reset in the middle of a stall.
    bus.ID_MulDiv = 1'b1;
    step("md_enter3", g);
    step("md_stall_a", g);
    step("md_stall_b", g);
    do_reset();
    bus.ID_MulDiv = 1'b0;
    step("md_post_rst", g); check("md_post_rst_out", {24'd0, g}, {24'd0, O_DEF});
`else
    // Without the mul/div option ID_MulDiv has no effect.
    bus.ID_MulDiv = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step("md_off", g); check("md_off_out", {24'd0, g}, {24'd0, O_DEF});
    end
    bus.ID_MulDiv = 1'b0;
    step("md_off_rel", g);
    bus.ID_Jump = 1'b1;
    step("pre_rst", g);
    do_reset();
    idle();
    step("post_rst", g); check("post_rst_out", {24'd0, g}, {24'd0, O_DEF});
`endif

    // Randomized traffic against the model.
    irq_acked = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      bus.ID_Rs          = 5'($urandom_range(0, 3));
      bus.ID_Rt          = 5'($urandom_range(0, 3));
      bus.EX_Rt          = 5'($urandom_range(0, 3));
      bus.ID_UsesRt      = 1'($urandom_range(0, 1));
      bus.EX_MemRead     = ($urandom_range(0, 2) == 0);
      bus.EX_BranchTaken = ($urandom_range(0, 7) == 0);
      bus.ID_Jump        = ($urandom_range(0, 5) == 0);
      bus.ID_MulDiv      = ($urandom_range(0, 7) == 0);
      if (bus.IRQ) begin
        if (irq_acked && ($urandom_range(0, 1) == 0)) begin
          bus.IRQ = 1'b0;
          irq_acked = 1'b0;
        end
      end else if ($urandom_range(0, 15) == 0) begin
        bus.IRQ = 1'b1;
      end
      step("rand", g);
      if (m_last_ack && bus.IRQ) irq_acked = 1'b1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
